// File: rtl/spi_program_loader_if.sv
// Bus bundle between the SPI program loader and its surroundings:
// the 3-wire SPI link from the host, the CPU programming port
// and the loader status flags.
interface spi_program_loader_if;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       cpu_ready;
    logic       cpu_done_load;
    logic [7:0] prog_data;
    logic       prog_valid;
    logic       programming;
    logic       busy;
    logic       overflow;
    logic       err;

    // Loader side: receives SPI and the CPU handshake, drives the program port.
    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n, cpu_ready, cpu_done_load,
        output prog_data, prog_valid, programming, busy, overflow, err
    );

    // Host/CPU side of the same bundle.
    modport master (
        output spi_sclk, spi_mosi, spi_cs_n, cpu_ready, cpu_done_load,
        input  prog_data, prog_valid, programming, busy, overflow, err
    );
endinterface

// File: rtl/spi_program_loader.sv
// SPI program loader: SPI mode-0 slave receiver, small byte FIFO and a
// session FSM that feeds the CPU programming port and waits for done-load.
// Optional build macro LOADER_CHECKSUM_EN: the host appends a modulo-256
// checksum byte after the image; a mismatch sets the sticky err flag.
module spi_program_loader #(
    parameter int PROG_BYTES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_program_loader_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(PROG_BYTES + 1);
    localparam logic [CW-1:0] LAST    = CW'(PROG_BYTES - 1);
    localparam logic [CW-1:0] RX_FULL = CW'(PROG_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    state_t        state_q;
    logic [2:0]    sclk_q;
    logic [1:0]    mosi_q;
    logic [2:0]    csn_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [FW-1:0] fcnt_q;
    logic [CW-1:0] bcnt_q, rx_q;
    logic          prog_q, busy_q, ovf_q, err_q;

    logic          sclk_rise, cs_low, cs_fall, byte_done;
    logic [7:0]    byte_val, head;
    logic          in_load, empty, full, valid, pop, push_req, push, ovf_hit;
    logic          start, load_done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, ck_q, sum_d, ck_val;
    logic          ck_got_q, ck_cap;
`endif

    // Two-flop synchronizers on all SPI pins, third flop on sclk/cs_n for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
            csn_q  <= 3'b111;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.spi_sclk};
            mosi_q <= {mosi_q[0], bus.spi_mosi};
            csn_q  <= {csn_q[1:0], bus.spi_cs_n};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_low    = ~csn_q[1];
    assign cs_fall   = csn_q[2] & ~csn_q[1];
    assign byte_done = cs_low & sclk_rise & (bit_q == 3'd7);
    assign byte_val  = {shift_q[6:0], mosi_q[1]};
    assign head      = mem_q[rd_q];

    // Bit counter: advances per sclk rise while selected, cleared when deselected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                bit_q <= 3'd0;
        else if (!cs_low)          bit_q <= 3'd0;
        else if (sclk_rise)        bit_q <= bit_q + 3'd1;
    end

    // Data path: shift register and FIFO storage carry no reset.
    always_ff @(posedge clk) begin
        if (cs_low && sclk_rise) shift_q <= byte_val;
        if (push)                mem_q[wr_q] <= byte_val;
    end

    // Handshake decode and session-completion condition.
    always_comb begin
        in_load  = (state_q == S_LOAD);
        empty    = (fcnt_q == '0);
        full     = (fcnt_q == FW'(FIFO_DEPTH));
        valid    = in_load && !empty;
        pop      = valid && bus.cpu_ready;
        push_req = byte_done && in_load && (rx_q != RX_FULL);
        push     = push_req && (!full || pop);
        ovf_hit  = push_req && full && !pop;
        start    = cs_fall && (state_q == S_IDLE || state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
        ck_cap    = byte_done && in_load && (rx_q == RX_FULL) && !ck_got_q;
        sum_d     = sum_q + (pop ? head : 8'h00);
        ck_val    = ck_got_q ? ck_q : byte_val;
        load_done = ((bcnt_q == RX_FULL) || (pop && bcnt_q == LAST)) &&
                    (ck_got_q || ck_cap);
`else
        load_done = pop && (bcnt_q == LAST);
`endif
    end

    // Session FSM with FIFO pointers, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
            rx_q    <= '0;
            prog_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= 8'h00;
            ck_q     <= 8'h00;
            ck_got_q <= 1'b0;
`endif
        end else if (start) begin
            state_q <= S_LOAD;
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
            rx_q    <= '0;
            prog_q  <= 1'b1;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= 8'h00;
            ck_got_q <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
                rx_q <= rx_q + CW'(1);
            end
            if (pop) begin
                rd_q   <= rd_q + AW'(1);
                bcnt_q <= bcnt_q + CW'(1);
            end
            if (push && !pop)      fcnt_q <= fcnt_q + FW'(1);
            else if (pop && !push) fcnt_q <= fcnt_q - FW'(1);
            if (ovf_hit)           ovf_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_d;
            if (ck_cap) begin
                ck_q     <= byte_val;
                ck_got_q <= 1'b1;
            end
`endif
            case (state_q)
                S_LOAD: if (load_done) begin
                    state_q <= S_WAIT;
`ifdef LOADER_CHECKSUM_EN
                    err_q   <= (ck_val != sum_d);
`endif
                end
                S_WAIT: if (bus.cpu_done_load) begin
                    state_q <= S_DONE;
                    prog_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.prog_valid  = valid;
    assign bus.prog_data   = valid ? head : 8'h00;
    assign bus.programming = prog_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = ovf_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_spi_program_loader.sv
// Directed bench for spi_program_loader: reset, full image load,
// back-pressure/overflow, partial-byte abort, mid-session reset and,
// when LOADER_CHECKSUM_EN is defined, checksum good/bad sessions.
module tb_spi_program_loader;
    logic clk = 1'b0;
    logic rst_n;

    spi_program_loader_if bus();

    spi_program_loader #(.PROG_BYTES(16), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp;
    } vec_t;

    vec_t       va [16];
    vec_t       vb [16];
    logic [7:0] img [16];
    logic [7:0] got [64];
    int         ngot = 0;
    int         bad_prog = 0;
    int         nvec = 0;
    int         nmis = 0;

    // Record every byte the CPU consumes; flag delivery outside programming mode.
    always @(negedge clk) begin
        if (bus.prog_valid && bus.cpu_ready) begin
            if (ngot < 64) got[ngot] = bus.prog_data;
            ngot++;
        end
        if (bus.prog_valid && !bus.programming) bad_prog++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_mosi = b[i];
            tick(4);
            bus.spi_sclk = 1'b1;
            tick(4);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        bus.spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_hi();
        tick(6);
        bus.spi_cs_n = 1'b1;
        tick(6);
    endtask

    // Sends img[] as one selected burst, plus the checksum byte when enabled.
    task automatic send_img(input logic [7:0] ck);
        cs_lo();
        for (int i = 0; i < 16; i++) spi_bits(img[i], 8);
`ifdef LOADER_CHECKSUM_EN
        spi_bits(ck, 8);
`else
        if (ck === 8'hxx) $display("note: unused checksum");
`endif
        cs_hi();
    endtask

    task automatic done_pulse();
        bus.cpu_done_load = 1'b1;
        tick(1);
        bus.cpu_done_load = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [7:0] ck;
        logic [7:0] vb_bytes [16];
        vb_bytes = '{8'h5A, 8'hC3, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'h34,
                     8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hA5};
        for (int i = 0; i < 16; i++) begin
            va[i] = '{tx: 8'(i), exp: 8'(i)};
            vb[i] = '{tx: vb_bytes[i], exp: vb_bytes[i]};
        end

        rst_n = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.cpu_ready = 1'b0;
        bus.cpu_done_load = 1'b0;

        // Reset held while SPI pins toggle.
        tick(2);
        repeat (4) begin
            bus.spi_sclk = 1'b1;
            bus.spi_mosi = ~bus.spi_mosi;
            tick(2);
            bus.spi_sclk = 1'b0;
            tick(2);
        end
        @(negedge clk);
        chk("rst_prog_data",   32'(bus.prog_data), 32'h0);
        chk("rst_prog_valid",  32'(bus.prog_valid), 32'h0);
        chk("rst_programming", 32'(bus.programming), 32'h0);
        chk("rst_busy",        32'(bus.busy), 32'h0);
        chk("rst_overflow",    32'(bus.overflow), 32'h0);
        chk("rst_err",         32'(bus.err), 32'h0);
        rst_n = 1'b1;
        tick(8);
        @(negedge clk);
        chk("idle_programming", 32'(bus.programming), 32'h0);
        chk("idle_busy",        32'(bus.busy), 32'h0);

        // Normal load 0x00..0x0F with cpu_ready high throughout.
        bus.cpu_ready = 1'b1;
        ngot = 0;
        for (int i = 0; i < 16; i++) img[i] = va[i].tx;
        send_img(8'h78);
        @(negedge clk);
        chk("norm_count", 32'(ngot), 32'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("norm_byte%0d", i), 32'(got[i]), 32'(va[i].exp));
        chk("wait_prog_valid",  32'(bus.prog_valid), 32'h0);
        chk("wait_programming", 32'(bus.programming), 32'h1);
        chk("wait_busy",        32'(bus.busy), 32'h1);
        chk("norm_err",         32'(bus.err), 32'h0);
        chk("norm_overflow",    32'(bus.overflow), 32'h0);
        tick(1);
        done_pulse();
        @(negedge clk);
        chk("done_programming", 32'(bus.programming), 32'h0);
        chk("done_busy",        32'(bus.busy), 32'h0);
        chk("load_prog_mode",   32'(bad_prog), 32'd0);

        // Back-pressure: 6 bytes into a 4-deep FIFO with cpu_ready low.
        bus.cpu_ready = 1'b0;
        cs_lo();
        for (int i = 0; i < 6; i++) spi_bits(8'h31 + 8'(i), 8);
        tick(6);
        @(negedge clk);
        chk("bp_busy",      32'(bus.busy), 32'h1);
        chk("bp_valid",     32'(bus.prog_valid), 32'h1);
        chk("bp_overflow",  32'(bus.overflow), 32'h1);
        chk("bp_head",      32'(bus.prog_data), 32'h31);
        ngot = 0;
        tick(1);
        bus.cpu_ready = 1'b1;
        tick(12);
        @(negedge clk);
        chk("bp_count", 32'(ngot), 32'd4);
        chk("bp_byte0", 32'(got[0]), 32'h31);
        chk("bp_byte1", 32'(got[1]), 32'h32);
        chk("bp_byte2", 32'(got[2]), 32'h33);
        chk("bp_byte3", 32'(got[3]), 32'h34);
        cs_hi();

        // Partial byte abort then a clean byte in the same session.
        ngot = 0;
        cs_lo();
        spi_bits(8'hFF, 5);
        cs_hi();
        cs_lo();
        spi_bits(8'hA5, 8);
        cs_hi();
        @(negedge clk);
        chk("abort_count",    32'(ngot), 32'd1);
        chk("abort_byte",     32'(got[0]), 32'hA5);
        chk("abort_ovf_stky", 32'(bus.overflow), 32'h1);
        chk("abort_session",  32'(bus.programming), 32'h1);

        // Mid-session reset after 7 bytes, then a clean 16-byte session.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        ngot = 0;
        cs_lo();
        for (int i = 0; i < 7; i++) spi_bits(vb[i].tx, 8);
        tick(4);
        @(negedge clk);
        chk("mid_count", 32'(ngot), 32'd7);
        chk("mid_prog",  32'(bus.programming), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_prog",  32'(bus.programming), 32'h0);
        chk("mid_rst_busy",  32'(bus.busy), 32'h0);
        chk("mid_rst_valid", 32'(bus.prog_valid), 32'h0);
        bus.spi_cs_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        ngot = 0;
        ck = 8'h00;
        for (int i = 0; i < 16; i++) begin
            img[i] = vb[i].tx;
            ck = ck + vb[i].tx;
        end
        send_img(ck);
        @(negedge clk);
        chk("post_count", 32'(ngot), 32'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("post_byte%0d", i), 32'(got[i]), 32'(vb[i].exp));
        chk("post_wait_busy", 32'(bus.busy), 32'h1);
        tick(1);
        done_pulse();
        @(negedge clk);
        chk("post_done_prog", 32'(bus.programming), 32'h0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good then bad.
        for (int i = 0; i < 16; i++) img[i] = 8'h01;
        ngot = 0;
        send_img(8'h10);
        @(negedge clk);
        chk("ck_good_count", 32'(ngot), 32'd16);
        chk("ck_good_err",   32'(bus.err), 32'h0);
        chk("ck_good_wait",  32'(bus.busy), 32'h1);
        tick(1);
        done_pulse();
        ngot = 0;
        send_img(8'h11);
        @(negedge clk);
        chk("ck_bad_count", 32'(ngot), 32'd16);
        chk("ck_bad_err",   32'(bus.err), 32'h1);
        tick(1);
        done_pulse();
        @(negedge clk);
        chk("ck_bad_sticky", 32'(bus.err), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/spi_program_loader.md
Name: spi_program_loader

Overview:
- Upstream feeder for the 8-bit CPU's programming port.
- Receives a program image over a 3-wire SPI-mode-0 slave link, buffers bytes in a small FIFO, and drives the CPU's programming signal and byte-wide program input.
- Sequences delivery with the CPU's ready handshake, then waits for the CPU's done-load before declaring the session complete.

Parameters:
- PROG_BYTES, 16: bytes per program image; equals CPU RAM size.
- FIFO_DEPTH, 4: receive buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, asynchronous; frequency <= clk/4.
- spi_mosi  in  1  SPI data, MSB first, sampled on SCLK rising edge.
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous.
- cpu_ready  in  1  CPU ready-for-UI; a byte is consumed in each cycle where cpu_ready=1 and prog_valid=1.
- cpu_done_load  in  1  CPU done-loading indication, level or pulse.
- prog_data  out  8  byte presented to the CPU program input (FIFO head).
- prog_valid  out  1  prog_data holds an undelivered byte.
- programming  out  1  CPU programming-mode request.
- busy  out  1  session in progress (not IDLE).
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- err  out  1  sticky checksum error (optional feature); constant 0 when the feature is absent.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, bit counter 0, byte counter 0, state IDLE; prog_data=0, prog_valid=0, programming=0, busy=0, overflow=0, err=0. Synchronizer flops reset: sclk and mosi to 0, cs_n to 1.
- Synchronization:
  - spi_sclk, spi_mosi and spi_cs_n each pass through a 2-flop synchronizer.
  - A third sclk flop provides edge detection.
  - Latency from a pin edge to internal action is 3 clk.
- Shifter:
  - Active while synced cs_n=0; each synced sclk rising edge shifts mosi into an 8-bit register.
  - On the 8th bit, the assembled byte is pushed to the FIFO in the same cycle and the bit counter returns to 0.
  - cs_n rising mid-byte discards the partial bits and zeroes the bit counter.
- FIFO: FIFO_DEPTH entries; prog_data = head entry; prog_valid = not empty.
  - Push and pop in the same cycle: both take effect, occupancy unchanged.
  - Push while full with no pop: byte dropped, overflow set.
- State machine:
  - IDLE: synced cs_n falling edge -> LOAD. On entry, clear FIFO, byte counter, overflow and err.
  - LOAD: programming=1.
    - Each pop (cpu_ready & prog_valid) increments the byte counter.
    - The pop of byte PROG_BYTES-1 moves to WAIT_DONE.
    - Bytes arriving after PROG_BYTES have been received are dropped without setting overflow.
  - WAIT_DONE: programming=1; prog_valid is forced to 0. cpu_done_load=1 -> DONE.
  - DONE: programming=0; busy=0. Synced cs_n falling edge -> LOAD with the same clears as IDLE.
  - busy=1 in LOAD and WAIT_DONE only.
- Byte counter width: clog2(PROG_BYTES+1). Counters never wrap within a session.
- cpu_done_load while in LOAD: ignored.
- cs_n rising before PROG_BYTES bytes: the session stays in LOAD; a later cs_n low continues shifting into the same session.
- rst_n low mid-session: immediate return to IDLE, all outputs at reset values, buffered bytes lost.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The host sends one extra byte after PROG_BYTES: the 8-bit modulo-256 sum of all image bytes.
  - The loader keeps a running sum of delivered bytes.
  - The checksum byte is captured internally and never presented on prog_data.
  - On capture, err=1 if it mismatches the sum; err is sticky until the next session.
  - WAIT_DONE is entered only after both all PROG_BYTES pops and checksum capture have occurred.
- Not defined: no checksum byte expected; err tied to 0; no sum logic present.

Test Plan:
- Reset check: hold rst_n=0 while driving SCLK/MOSI -> all outputs 0; after release, state IDLE and programming=0.
- Normal load: send bytes 0x00..0x0F, cpu_ready=1 continuously -> prog_data sequence 0x00..0x0F in order, each with prog_valid=1; programming=1 throughout; after the 16th pop prog_valid=0; pulse cpu_done_load -> programming=0, busy=0.
- Back-pressure and overflow: cpu_ready=0, send 6 bytes with FIFO_DEPTH=4 -> prog_valid=1, overflow=1, and only the first 4 bytes delivered after cpu_ready rises.
- Partial byte abort: send 5 bits, raise cs_n, lower cs_n, send 0xA5 -> the next delivered byte is 0xA5.
- Mid-session reset: assert rst_n=0 after 7 bytes delivered -> immediate IDLE, programming=0; a new 16-byte session then loads correctly.
- Checksum (with LOADER_CHECKSUM_EN): image 0x01 x16 with checksum 0x10 -> err=0; a repeat session with checksum 0x11 -> err=1, and the 16 image bytes are still delivered.
